// File: rtl/manta_uart_pkg.sv
// Shared constants, state encodings and hex helpers for the Manta UART receive path.
// No logic of its own; the helpers are pure combinational functions.
// MANTA_RX_LOWERCASE_EN: when defined, lowercase a-f are accepted as hex digits.
package manta_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_W  = 8'h57;

    typedef enum logic [1:0] {
        P_IDLE,
        P_READ,
        P_WRITE
    } parser_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic logic is_hex(input logic [7:0] c);
        logic hit;
        hit = ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
`ifdef MANTA_RX_LOWERCASE_EN
        hit = hit || ((c >= 8'h61) && (c <= 8'h66));
`endif
        return hit;
    endfunction

    // Letters sit at 0x41/0x61 + n, so the low nibble plus 9 gives 10..15.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        logic [3:0] n;
        n = 4'd0;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            n = c[3:0];
        end else if ((c >= 8'h41) && (c <= 8'h46)) begin
            n = c[3:0] + 4'd9;
        end
`ifdef MANTA_RX_LOWERCASE_EN
        else if ((c >= 8'h61) && (c <= 8'h66)) begin
            n = c[3:0] + 4'd9;
        end
`endif
        return n;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling, 8N1 framing check.
// Latency: byte strobe one cycle after the stop-bit sample (mid stop bit).
// No backpressure: the strobe is a single-cycle pulse the consumer must take.
module uart_rx
    import manta_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             baud_hit;
    logic             sample_bit;
    logic             stop_good;

    // Synchroniser, state register, baud counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift_q  <= 8'h00;
            data_o   <= 8'h00;
            valid_o  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            state   <= state_nxt;
            valid_o <= stop_good;
            if (stop_good) begin
                data_o <= shift_q;
            end
            // The counter restarts on every state change and every bit boundary.
            if ((state == RX_IDLE) || (state == RX_WAIT_HIGH) ||
                (state_nxt != state) || baud_hit) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state == RX_START) begin
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
                shift_q <= {rx_sync, shift_q[7:1]};
            end
        end
    end

    // Next-state selection for the frame receiver.
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:      if (!rx_sync) state_nxt = RX_START;
            RX_START:     if (baud_hit) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (sample_bit && (bit_idx == 3'd7)) state_nxt = RX_STOP;
            RX_STOP:      if (baud_hit) state_nxt = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) state_nxt = RX_IDLE;
            default:      state_nxt = RX_IDLE;
        endcase
    end

    // Sample-point decode: half a bit in START, a full bit elsewhere.
    always_comb begin
        baud_hit   = (state == RX_START) ? (baud_cnt == HALF_LAST) : (baud_cnt == BAUD_LAST);
        sample_bit = (state == RX_DATA) && baud_hit;
        stop_good  = (state == RX_STOP) && baud_hit && rx_sync;
    end

endmodule

// File: rtl/uart_rx_bridge.sv
// Manta host request parser: ASCII R/W hex requests over UART -> one bus transaction each.
// Latency: valid_o/err_o one cycle after the terminator's byte strobe.
// No backpressure: bytes arrive at least 10 bit-times apart; MANTA_RX_LOWERCASE_EN enables a-f.
module uart_rx_bridge
    import manta_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o,
    output logic        err_o
);

    logic [7:0]    byte_dat;
    logic          byte_vld;
    parser_state_t state;
    parser_state_t state_nxt;
    logic [31:0]   buf_q;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_lim;
    logic          is_term;
    logic          is_digit;
    logic          take_digit;
    logic          fire_vld;
    logic          fire_err;

    uart_rx #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .data_o  (byte_dat),
        .valid_o (byte_vld)
    );

    // Parser state, digit buffer and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= P_IDLE;
            buf_q   <= 32'h0;
            cnt_q   <= 4'd0;
            addr_o  <= 16'h0;
            data_o  <= 16'h0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_o <= fire_vld;
            err_o   <= fire_err;
            // The buffer is cleared while idle so every request starts from zero.
            if (state == P_IDLE) begin
                buf_q <= 32'h0;
                cnt_q <= 4'd0;
            end else if (take_digit) begin
                buf_q <= {buf_q[27:0], hex_to_nibble(byte_dat)};
                cnt_q <= cnt_q + 4'd1;
            end
            if (fire_vld) begin
                rw_o   <= (state == P_WRITE);
                addr_o <= (state == P_WRITE) ? buf_q[31:16] : buf_q[15:0];
                data_o <= (state == P_WRITE) ? buf_q[15:0] : 16'h0;
            end
        end
    end

    // Next-state: command letters open a request; any non-digit byte closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            P_IDLE: begin
                if (byte_vld && (byte_dat == ASCII_R)) state_nxt = P_READ;
                else if (byte_vld && (byte_dat == ASCII_W)) state_nxt = P_WRITE;
            end
            P_READ, P_WRITE: begin
                if (byte_vld && !take_digit) state_nxt = P_IDLE;
            end
            default: state_nxt = P_IDLE;
        endcase
    end

    // Byte classification and the valid / error / accept-digit decisions.
    always_comb begin
        is_term    = (byte_dat == ASCII_CR) || (byte_dat == ASCII_LF);
        is_digit   = is_hex(byte_dat);
        cnt_lim    = (state == P_WRITE) ? 4'd8 : 4'd4;
        take_digit = 1'b0;
        fire_vld   = 1'b0;
        fire_err   = 1'b0;
        if (byte_vld && (state != P_IDLE)) begin
            if (is_term) begin
                fire_vld = (cnt_q == cnt_lim);
                fire_err = (cnt_q != cnt_lim);
            end else if (is_digit && (cnt_q != cnt_lim)) begin
                take_digit = 1'b1;
            end else begin
                fire_err = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Directed bench for uart_rx_bridge: UART frames in, scoreboarded bus requests out.
// Expected transactions are queued at issue time and popped by an output monitor.
// Honours MANTA_RX_LOWERCASE_EN for the lowercase-hex expectation.
`timescale 1ns/1ps
module tb_uart_rx_bridge;

    localparam int CPB = 8;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;
    logic        err_o;

    typedef struct packed {
        logic        is_err;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   applied     = 0;
    int   miscompares = 0;
    int   strobe_cnt  = 0;

    uart_rx_bridge #(
        .CLOCKS_PER_BAUD(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .rw_o    (rw_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_ok(input logic rw, input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        e.is_err = 1'b0;
        e.rw     = rw;
        e.addr   = addr;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '0;
        e.is_err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
        end
    endtask

    // Output monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dut.u_rx.valid_o) strobe_cnt++;
            if (valid_o && err_o) begin
                applied++;
                miscompares++;
                $display("FAIL exclusive: valid_o and err_o both high");
            end else if (valid_o || err_o) begin
                applied++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected: valid=%0b err=%0b addr=0x%0h data=0x%0h rw=%0b, required no pulse",
                             valid_o, err_o, addr_o, data_o, rw_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        if (!err_o) begin
                            miscompares++;
                            $display("FAIL err_pulse: got valid addr=0x%0h, required err_o", addr_o);
                        end
                    end else if (!valid_o || (rw_o !== e.rw) || (addr_o !== e.addr) || (data_o !== e.data)) begin
                        miscompares++;
                        $display("FAIL request: got valid=%0b rw=%0b addr=0x%0h data=0x%0h, required rw=%0b addr=0x%0h data=0x%0h",
                                 valid_o, rw_o, addr_o, data_o, e.rw, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int s0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_addr",  32'(addr_o),  32'h0);
        check("reset_data",  32'(data_o),  32'h0);
        check("reset_rw",    32'(rw_o),    32'h0);
        check("reset_valid", 32'(valid_o), 32'h0);
        check("reset_err",   32'(err_o),   32'h0);

        // Read with CRLF: one request, LF ignored.
        push_ok(1'b0, 16'h1234, 16'h0000);
        send_str("R1234");
        send_byte(CR, 1'b1);
        send_byte(LF, 1'b1);

        // Write, then outputs must hold.
        push_ok(1'b1, 16'h00AB, 16'h5A5A);
        send_str("W00AB5A5A");
        send_byte(CR, 1'b1);
        repeat (20) @(negedge clk);
        check("hold_addr", 32'(addr_o), 32'h00AB);
        check("hold_data", 32'(data_o), 32'h5A5A);
        check("hold_rw",   32'(rw_o),   32'h1);

        // Short read, then a write with a 9th digit; its CR is ignored.
        push_err();
        send_str("R12");
        send_byte(CR, 1'b1);
        push_err();
        send_str("W123456789");
        send_byte(CR, 1'b1);

        // Lowercase hex.
`ifdef MANTA_RX_LOWERCASE_EN
        push_ok(1'b0, 16'hABCD, 16'h0000);
`else
        push_err();
`endif
        send_str("Rabcd");
        send_byte(CR, 1'b1);

        // 'R' with a low stop bit must be dropped, so the next read parses cleanly.
        s0 = strobe_cnt;
        send_byte(8'h52, 1'b0);
        check("framing_no_strobe", 32'(strobe_cnt - s0), 32'h0);
        push_ok(1'b0, 16'h0001, 16'h0000);
        send_str("R0001");
        send_byte(CR, 1'b1);

        // Reset mid-request discards the partial write.
        send_str("W1234");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_addr", 32'(addr_o), 32'h0);
        check("rst_rw",   32'(rw_o),   32'h0);
        push_ok(1'b0, 16'h0002, 16'h0000);
        send_str("R0002");
        send_byte(CR, 1'b1);

        repeat (4 * CPB) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
